adc_frame_sequencer: RTL and testbench

//   Sequences conversion frames of the serial 8-channel 12-bit ADC using the

---
 rtl/adc_pkg.sv | 23 ++
 rtl/adc_frame_sequencer_if.sv | 29 ++
 rtl/adc_rr_select.sv | 27 ++
 rtl/adc_frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_adc_frame_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared widths, FSM state type and config-word builder for the serial
// 8-channel 12-bit ADC frame sequencer.
package adc_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CFG_W  = 6;
    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W   = 3;

    typedef enum logic [2:0] {
        StIdle,
        StConvst,
        StConv,
        StShift,
        StDone
    } adc_state_e;

    // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, no sleep.
    function automatic logic [CFG_W-1:0] cfg_word(input logic [CH_W-1:0] ch);
        return {1'b1, ch[0], ch[2:1], 1'b1, 1'b0};
    endfunction

endpackage

// File: rtl/adc_frame_sequencer_if.sv
// Strobe, control, ADC serial pins and sample output of the frame sequencer.
// The slave modport is the sequencer; the master side drives strobes and SDO.
interface adc_frame_sequencer_if;
    import adc_pkg::*;

    logic              pe_sclk;
    logic              ne_sclk_n;
    logic              run;
    logic [NUM_CH-1:0] chan_mask;
    logic              adc_convst;
    logic              adc_sclk;
    logic              adc_sdi;
    logic              adc_sdo;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_chan;
    logic              busy;

    modport master (
        output pe_sclk, ne_sclk_n, run, chan_mask, adc_sdo,
        input  adc_convst, adc_sclk, adc_sdi, sample_valid, sample_data, sample_chan, busy
    );

    modport slave (
        input  pe_sclk, ne_sclk_n, run, chan_mask, adc_sdo,
        output adc_convst, adc_sclk, adc_sdi, sample_valid, sample_data, sample_chan, busy
    );

endinterface

// File: rtl/adc_rr_select.sv
// Round-robin channel picker: first enabled channel after ptr_i, wrapping,
// with ptr_i itself considered last.
module adc_rr_select
    import adc_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   next_o,
    output logic              any_o
);

    logic [CH_W-1:0] idx;

    always_comb begin
        next_o = ptr_i;
        idx    = ptr_i;
        any_o  = |mask_i;
        // Walk farthest-first so the nearest enabled channel is the last write.
        for (int k = int'(NUM_CH); k >= 1; k--) begin
            idx = ptr_i + CH_W'(k);
            if (mask_i[idx]) begin
                next_o = idx;
            end
        end
    end

endmodule

// File: rtl/adc_frame_sequencer.sv
// Frame sequencer: CONVST, conversion wait, SCLK-gated config/data shift and a
// one-frame-delayed sample output, all paced by the external SCLK phase strobes.
module adc_frame_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned CONVST_PERIODS = 1,
    parameter int unsigned CONV_PERIODS   = 4
) (
    input logic                  clk_clk,
    input logic                  reset_n,
    adc_frame_sequencer_if.slave bus
);

    localparam int unsigned BitW = $clog2(DATA_W + 1);

    adc_state_e        state_q, state_d;
    logic [7:0]        per_cnt_q, per_cnt_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CFG_W-1:0]  cfg_sh_q, cfg_sh_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   prev_chan_q, prev_chan_d;
    logic              first_frame_q, first_frame_d;
    logic              convst_q, convst_d;
    logic              sclk_q, sclk_d;
    logic              sdi_q, sdi_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   chan_q, chan_d;

    logic [CH_W-1:0]   next_ch;
    logic              any_en;
    logic [CFG_W-1:0]  cfg_cur;

    adc_rr_select u_rr_select (
        .mask_i (bus.chan_mask),
        .ptr_i  (ptr_q),
        .next_o (next_ch),
        .any_o  (any_en)
    );

    assign cfg_cur = cfg_word(ptr_q);

    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        cfg_sh_d      = cfg_sh_q;
        ptr_d         = ptr_q;
        prev_chan_d   = prev_chan_q;
        first_frame_d = first_frame_q;
        convst_d      = convst_q;
        sclk_d        = sclk_q;
        sdi_d         = sdi_q;
        valid_d       = 1'b0;
        data_d        = data_q;
        chan_d        = chan_q;

        unique case (state_q)
            StIdle: begin
                // Stopping breaks the conversion pipeline, so the next frame is a dummy.
                if (!bus.run) begin
                    first_frame_d = 1'b1;
                end
                if (bus.pe_sclk && bus.run && any_en) begin
                    ptr_d     = next_ch;
                    convst_d  = 1'b1;
                    per_cnt_d = 8'd1;
                    state_d   = StConvst;
                end
            end
            StConvst: begin
                if (bus.pe_sclk) begin
                    if (32'(per_cnt_q) >= CONVST_PERIODS) begin
                        convst_d  = 1'b0;
                        per_cnt_d = '0;
                        state_d   = StConv;
                    end else begin
                        per_cnt_d = per_cnt_q + 8'd1;
                    end
                end
            end
            StConv: begin
                if (bus.pe_sclk) begin
                    if (32'(per_cnt_q) + 32'd1 >= CONV_PERIODS) begin
                        sdi_d     = cfg_cur[CFG_W-1];
                        cfg_sh_d  = {cfg_cur[CFG_W-2:0], 1'b0};
                        bit_cnt_d = '0;
                        state_d   = StShift;
                    end else begin
                        per_cnt_d = per_cnt_q + 8'd1;
                    end
                end
            end
            StShift: begin
                if (bus.pe_sclk) begin
                    if (bit_cnt_q != BitW'(DATA_W)) begin
                        sclk_d    = 1'b1;
                        shreg_d   = {shreg_q[DATA_W-2:0], bus.adc_sdo};
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else if (!bus.ne_sclk_n && bit_cnt_q != '0) begin
                    // The ne before the first rising edge leaves the MSB on SDI.
                    sclk_d   = 1'b0;
                    sdi_d    = cfg_sh_q[CFG_W-1];
                    cfg_sh_d = {cfg_sh_q[CFG_W-2:0], 1'b0};
                    if (bit_cnt_q == BitW'(DATA_W)) begin
                        state_d = StDone;
                        if (!first_frame_q) begin
                            valid_d = 1'b1;
                            data_d  = shreg_q;
                            chan_d  = prev_chan_q;
                        end
                    end
                end
            end
            StDone: begin
                first_frame_d = 1'b0;
                prev_chan_d   = ptr_q;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            per_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            cfg_sh_q      <= '0;
            ptr_q         <= '0;
            prev_chan_q   <= '0;
            first_frame_q <= 1'b1;
            convst_q      <= 1'b0;
            sclk_q        <= 1'b0;
            sdi_q         <= 1'b0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            chan_q        <= '0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            cfg_sh_q      <= cfg_sh_d;
            ptr_q         <= ptr_d;
            prev_chan_q   <= prev_chan_d;
            first_frame_q <= first_frame_d;
            convst_q      <= convst_d;
            sclk_q        <= sclk_d;
            sdi_q         <= sdi_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            chan_q        <= chan_d;
        end
    end

    assign bus.adc_convst   = convst_q;
    assign bus.adc_sclk     = sclk_q;
    assign bus.adc_sdi      = sdi_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_chan  = chan_q;
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed + randomized bench for adc_frame_sequencer with an SDO-driving ADC
// model and a round-robin / pipeline reference model.
module tb_adc_frame_sequencer;
    import adc_pkg::*;

    logic clk_clk = 1'b0;
    logic reset_n;

    adc_frame_sequencer_if bus ();

    adc_frame_sequencer #(
        .CONVST_PERIODS (1),
        .CONV_PERIODS   (4)
    ) dut (
        .clk_clk (clk_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // SCLK phase strobes: pe every 24 clks, ne (active low) 12 clks later.
    int ph = 0;
    initial begin
        bus.pe_sclk   = 1'b0;
        bus.ne_sclk_n = 1'b1;
        forever begin
            @(negedge clk_clk);
            bus.pe_sclk   = (ph == 0);
            bus.ne_sclk_n = (ph != 12);
            ph = (ph == 23) ? 0 : ph + 1;
        end
    end

    // ADC model: new word per CONVST, MSB first, next bit after each SCLK rise;
    // SDI is captured on every SCLK rise.
    logic [3:0]  rises = 4'd0;
    logic [11:0] sdi_cap = 12'd0;
    logic [11:0] adc_word = 12'd0;
    logic [11:0] forced_word = 12'd0;
    bit          force_en = 1'b0;
    initial begin
        bus.adc_sdo = 1'b0;
        forever begin
            @(posedge bus.adc_sclk or posedge bus.adc_convst);
            if (bus.adc_convst) begin
                rises    = 4'd0;
                sdi_cap  = 12'd0;
                adc_word = force_en ? forced_word : 12'($urandom);
            end else if (rises < 4'd12) begin
                sdi_cap[4'd11 - rises] = bus.adc_sdi;
                rises = rises + 4'd1;
            end
            bus.adc_sdo = (rises < 4'd12) ? adc_word[4'd11 - rises] : 1'b0;
        end
    end

    // Reference model state: last picked channel and channel of previous frame.
    int m_ptr  = 0;
    int m_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] mask, input int ptr);
        logic [2:0] c;
        for (int k = 1; k <= 8; k++) begin
            c = 3'((ptr + k) % 8);
            if (mask[c]) return int'(c);
        end
        return -1;
    endfunction

    function automatic logic [5:0] exp_cfg(input int ch);
        logic [2:0] c;
        c = 3'(ch);
        return {1'b1, c[0], c[2:1], 1'b1, 1'b0};
    endfunction

    // Follows one frame from launch to IDLE. drop_at/rst_at: SCLK pulse count at
    // which run is dropped / reset is asserted (-1 = never).
    task automatic do_frame(input bit exp_valid, input int drop_at, input int rst_at,
                            input string tag);
        int t, convst_len, pulses, nval, sclk_bad, exp_ch;
        logic sclk_prev;
        logic [11:0] vdata;
        logic [2:0] vchan;
        t = 0; convst_len = 0; pulses = 0; nval = 0; sclk_bad = 0;
        sclk_prev = 1'b0; vdata = '0; vchan = '0;
        while (!bus.adc_convst && t < 100) begin
            @(negedge clk_clk);
            t++;
        end
        chk({tag, "_launch"}, 32'(bus.adc_convst), 32'd1);
        if (!bus.adc_convst) return;
        exp_ch = rr_pick(bus.chan_mask, m_ptr);
        m_ptr  = exp_ch;
        t = 0;
        while (t < 2000) begin
            if (bus.adc_convst) begin
                convst_len++;
                if (bus.adc_sclk) sclk_bad++;
            end
            if (bus.adc_sclk && !sclk_prev) pulses++;
            sclk_prev = bus.adc_sclk;
            if (bus.sample_valid) begin
                nval++;
                vdata = bus.sample_data;
                vchan = bus.sample_chan;
            end
            if (!bus.busy) break;
            if (pulses == drop_at) bus.run = 1'b0;
            if (pulses == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk({tag, "_async_reset_outputs"},
                    32'({bus.adc_convst, bus.adc_sclk, bus.adc_sdi, bus.sample_valid,
                         bus.sample_data, bus.sample_chan, bus.busy}), 32'd0);
                repeat (3) @(negedge clk_clk);
                reset_n = 1'b1;
                m_ptr   = 0;
                return;
            end
            @(negedge clk_clk);
            t++;
        end
        chk({tag, "_frame_end"}, 32'(t < 2000), 32'd1);
        chk({tag, "_convst_len"}, 32'(convst_len), 32'd24);
        chk({tag, "_sclk_pulses"}, 32'(pulses), 32'd12);
        chk({tag, "_sclk_in_convst"}, 32'(sclk_bad), 32'd0);
        chk({tag, "_sdi_bits"}, 32'(sdi_cap), 32'({exp_cfg(exp_ch), 6'b0}));
        chk({tag, "_valid_count"}, 32'(nval), 32'(exp_valid));
        if (exp_valid) begin
            chk({tag, "_sample_data"}, 32'(vdata), 32'(adc_word));
            chk({tag, "_sample_chan"}, 32'(vchan), 32'(m_prev));
        end
        chk({tag, "_idle_pins"}, 32'({bus.adc_convst, bus.adc_sclk}), 32'd0);
        m_prev = exp_ch;
    endtask

    int exp_seq [4] = '{0, 2, 5, 0};
    int cnt_convst, cnt_sclk, cnt_busy, t_launch;

    initial begin
        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.chan_mask = 8'h00;
        repeat (3) @(negedge clk_clk);
        chk("reset_outputs",
            32'({bus.adc_convst, bus.adc_sclk, bus.adc_sdi, bus.sample_valid,
                 bus.sample_data, bus.sample_chan, bus.busy}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_clk);

        // Single channel 0, fixed ADC word; first frame is a dummy.
        force_en      = 1'b1;
        forced_word   = 12'hA5C;
        bus.chan_mask = 8'h01;
        bus.run       = 1'b1;
        do_frame(1'b0, -1, -1, "ch0_f1");
        chk("ch0_cfg_100010", 32'(sdi_cap[11:6]), 32'(6'b100010));
        do_frame(1'b1, -1, -1, "ch0_f2");
        chk("ch0_data_A5C", 32'(bus.sample_data), 32'h0A5C);
        chk("ch0_chan", 32'(bus.sample_chan), 32'd0);
        force_en = 1'b0;

        // Mask 0x25: round robin 2,5,0,... so samples report 0,2,5,0.
        bus.chan_mask = 8'h25;
        for (int i = 0; i < 4; i++) begin
            do_frame(1'b1, -1, -1, "mask25");
            chk("mask25_chan_seq", 32'(bus.sample_chan), 32'(exp_seq[i]));
            if (i == 1) chk("ch5_cfg_111010", 32'(sdi_cap[11:6]), 32'(6'b111010));
        end

        // Run dropped mid-SHIFT: frame completes with its sample, then stays idle.
        do_frame(1'b1, 3, -1, "run_drop");
        cnt_convst = 0; cnt_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_clk);
            if (bus.adc_convst) cnt_convst++;
            if (bus.busy) cnt_busy++;
        end
        chk("run_drop_no_convst", 32'(cnt_convst), 32'd0);
        chk("run_drop_not_busy", 32'(cnt_busy), 32'd0);

        // Empty mask: nothing launches; then a single high channel.
        bus.chan_mask = 8'h00;
        bus.run       = 1'b1;
        cnt_convst = 0; cnt_sclk = 0; cnt_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_clk);
            if (bus.adc_convst) cnt_convst++;
            if (bus.adc_sclk) cnt_sclk++;
            if (bus.busy) cnt_busy++;
        end
        chk("mask0_no_convst", 32'(cnt_convst), 32'd0);
        chk("mask0_no_sclk", 32'(cnt_sclk), 32'd0);
        chk("mask0_not_busy", 32'(cnt_busy), 32'd0);
        bus.chan_mask = 8'h80;
        t_launch = 0;
        while (!bus.adc_convst && t_launch < 100) begin
            @(negedge clk_clk);
            t_launch++;
        end
        chk("mask80_launch_next_pe", 32'(t_launch <= 25), 32'd1);
        do_frame(1'b0, -1, -1, "ch7_f1");
        do_frame(1'b1, -1, -1, "ch7_f2");
        chk("ch7_chan", 32'(bus.sample_chan), 32'd7);

        // Reset in the middle of SHIFT, then the dummy frame after release.
        do_frame(1'b0, -1, 5, "mid_reset");
        do_frame(1'b0, -1, -1, "post_reset_f1");
        do_frame(1'b1, -1, -1, "post_reset_f2");

        // Random non-empty masks, changed between frames.
        for (int i = 0; i < 6; i++) begin
            bus.chan_mask = 8'($urandom_range(1, 255));
            do_frame(1'b1, -1, -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
